// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin arbiter sharing the common data bus between units,
//            with a one-entry result slot per unit and a registered broadcast.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int RSV_ID_W = 6,
    parameter int DATA_W   = 32,
    parameter int N_REQ    = 4,
    parameter int SRC_W    = $clog2(N_REQ),
    parameter int CDB_W    = RSV_ID_W + DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*CDB_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   flush,
    output logic                   cdb_valid,
    output logic [CDB_W-1:0]       cdb,
    output logic [SRC_W-1:0]       cdb_src,
    output logic                   busy
);

    localparam int IDX_W = SRC_W + 1;

    logic [N_REQ-1:0] slot_valid;
    logic [CDB_W-1:0] slot_data [N_REQ];
    logic [SRC_W-1:0] ptr;

    logic [N_REQ-1:0] grant;
    logic [SRC_W-1:0] grant_idx;
    logic             any_grant;
    logic [IDX_W-1:0] cand;
    logic [N_REQ-1:0] accept;

    // Rotating search from ptr; the extra index bit absorbs the wrap for any N_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + IDX_W'(k);
            if (cand >= IDX_W'(N_REQ)) begin
                cand = cand - IDX_W'(N_REQ);
            end
            if (!any_grant && slot_valid[cand[SRC_W-1:0]]) begin
                any_grant = 1'b1;
                grant_idx = cand[SRC_W-1:0];
            end
        end
        if (flush) begin
            any_grant = 1'b0;
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = ~{N_REQ{flush}} & (~slot_valid | grant);
    assign accept    = req_valid & req_ready;
    assign busy      = |slot_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            ptr        <= '0;
            cdb_valid  <= 1'b0;
            cdb        <= '0;
            cdb_src    <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                slot_data[i] <= '0;
            end
        end else if (flush) begin
            slot_valid <= '0;
            cdb_valid  <= 1'b0;
        end else begin
            // A granted slot refilled in the same cycle stays valid.
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_data[i]  <= req_data[i*CDB_W +: CDB_W];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
            cdb_valid <= any_grant;
            if (any_grant) begin
                cdb     <= slot_data[grant_idx];
                cdb_src <= grant_idx;
                ptr     <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Scoreboard bench for cdb_arbiter against a slot/queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int N     = 4;
    localparam int RW    = 6;
    localparam int DW    = 32;
    localparam int SW    = 2;
    localparam int CW    = RW + DW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*CW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              flush = 1'b0;
    logic              cdb_valid;
    logic [CW-1:0]     cdb;
    logic [SW-1:0]     cdb_src;
    logic              busy;

    cdb_arbiter #(.RSV_ID_W(RW), .DATA_W(DW), .N_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .cdb_valid(cdb_valid),
        .cdb(cdb), .cdb_src(cdb_src), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        int            src;
        logic [CW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: per-unit holding slot, rotating start pointer, last broadcast.
    bit            m_valid [N];
    logic [CW-1:0] m_data  [N];
    int            m_ptr;
    int            m_last_src;
    logic [CW-1:0] m_last_data;
    bit            started = 0;

    // Monitor: one expected broadcast state per clock edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (cdb_valid !== e.v || cdb !== e.data || int'(cdb_src) != e.src) begin
                fails++;
                $display("FAIL cdb_bus: got v=%0b src=%0d data=%h, want v=%0b src=%0d data=%h",
                         cdb_valid, cdb_src, cdb, e.v, e.src, e.data);
            end
        end
    end

    function automatic logic [CW-1:0] rnd_word();
        return {RW'($urandom), DW'($urandom)};
    endfunction

    function automatic logic [N*CW-1:0] rnd_bus();
        logic [N*CW-1:0] d;
        for (int i = 0; i < N; i++) d[i*CW +: CW] = rnd_word();
        return d;
    endfunction

    task automatic cycle(input logic [N-1:0] rv, input logic [N*CW-1:0] d,
                         input logic fl, input logic r);
        int       g;
        logic [N-1:0] er;
        bit       eb;
        exp_t     e;
        @(negedge clk);
        req_valid = rv;
        req_data  = d;
        flush     = fl;
        rst       = r;
        #1;
        g = -1;
        if (!fl) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        eb = 0;
        for (int i = 0; i < N; i++) begin
            er[i] = !fl && (!m_valid[i] || g == i);
            eb    = eb | m_valid[i];
        end
        if (started) begin
            tests++;
            if (req_ready !== er || busy !== eb) begin
                fails++;
                $display("FAIL ready_busy: got ready=%b busy=%b, want ready=%b busy=%b",
                         req_ready, busy, er, eb);
            end
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_data[i]  = '0;
            end
            m_ptr = 0; m_last_src = 0; m_last_data = '0;
            e = '{1'b0, 0, '0};
            started = 1;
        end else if (fl) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            e = '{1'b0, m_last_src, m_last_data};
        end else begin
            if (g >= 0) begin
                e = '{1'b1, g, m_data[g]};
                m_last_src = g; m_last_data = m_data[g];
                m_valid[g] = 0;
                m_ptr = (g + 1) % N;
            end else begin
                e = '{1'b0, m_last_src, m_last_data};
            end
            for (int i = 0; i < N; i++) begin
                if (rv[i] && er[i]) begin
                    m_valid[i] = 1;
                    m_data[i]  = d[i*CW +: CW];
                end
            end
        end
        if (started) sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, rnd_bus(), 1'b0, 1'b0);
    endtask

    initial begin
        logic [N*CW-1:0] d;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_data[i] = '0;
        end
        m_ptr = 0; m_last_src = 0; m_last_data = '0;

        cycle('0, '0, 1'b0, 1'b1);
        cycle('0, '0, 1'b0, 1'b1);
        idle(2);

        // Single request from unit 2: tag 5, data DEAD.
        d = rnd_bus();
        d[2*CW +: CW] = {RW'(5), DW'(32'hDEAD)};
        cycle(4'b0100, d, 1'b0, 1'b0);
        idle(4);

        // All units streaming continuously.
        for (int c = 0; c < 16; c++) cycle(4'b1111, rnd_bus(), 1'b0, 1'b0);
        idle(6);

        // Unit 1 streams 8 results back to back.
        for (int c = 0; c < 8; c++) cycle(4'b0010, rnd_bus(), 1'b0, 1'b0);
        idle(4);

        // Rotation: grant unit 0 alone (ptr becomes 1), then load slots 0 and 3.
        cycle(4'b0001, rnd_bus(), 1'b0, 1'b0);
        idle(3);
        cycle(4'b1001, rnd_bus(), 1'b0, 1'b0);
        idle(4);

        // Flush with slots 0, 2, 3 full and a broadcast in flight.
        cycle(4'b0010, rnd_bus(), 1'b0, 1'b0);
        cycle(4'b1101, rnd_bus(), 1'b0, 1'b0);
        cycle(4'b0000, rnd_bus(), 1'b1, 1'b0);
        idle(4);

        // Reset with slots full and a broadcast in flight.
        cycle(4'b0010, rnd_bus(), 1'b0, 1'b0);
        cycle(4'b1101, rnd_bus(), 1'b0, 1'b0);
        cycle(4'b0000, rnd_bus(), 1'b0, 1'b1);
        idle(4);

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            cycle(N'($urandom), rnd_bus(), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 199) == 0));
        end
        idle(6);

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between N_REQ execution units that complete results for reservation stations.
- Each unit hands over one {rob/rsv tag, data} result per handshake; the block buffers it in a one-entry slot per unit.
- The block picks one slot per cycle by round-robin and drives the registered cdb_valid/cdb broadcast consumed by all reservation stations and the ROB.
- The CDB has no backpressure; the arbiter is the only driver of cdb_valid/cdb.

Parameters:
- N_REQ, 4, number of requesting execution units; legal range 2..8.
- SRC_W, $clog2(N_REQ), width of cdb_src.
- CDB_W, RSV_ID_W+DATA_W from fcpu_pkg, result word: tag in [DATA_W+:RSV_ID_W], data in [0+:DATA_W].

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high; when high at a rising edge, all state goes to reset values.
- req_valid  in  N_REQ  unit i offers a result.
- req_data  in  N_REQ*CDB_W  unit i result in [i*CDB_W+:CDB_W].
- req_ready  out  N_REQ  unit i may hand over a result this cycle.
- flush  in  1  squash all buffered and pending results (mispredict/exception).
- cdb_valid  out  1  broadcast valid, one-cycle pulse per result.
- cdb  out  CDB_W  broadcast word.
- cdb_src  out  SRC_W  index of the unit whose result is on cdb.
- busy  out  1  |slot_valid, combinational.

Behaviour:
- State:
  - slot_valid[N_REQ], slot_data[N_REQ][CDB_W].
  - ptr (SRC_W bits).
  - registered cdb_valid, cdb, cdb_src.
- Reset values: slot_valid=0, slot_data=0, ptr=0, cdb_valid=0, cdb=0, cdb_src=0. busy=0 and req_ready all 1 in the cycle after reset.
- Grant (combinational, from slots only; req inputs are never granted directly):
  - Search starts at ptr and wraps modulo N_REQ.
  - grant[g]=1 for the first g with slot_valid[g]=1.
  - At most one grant per cycle. No grant when no slot is valid or flush=1.
- req_ready[i] = ~flush & (~slot_valid[i] | grant[i]). A full slot that is granted this cycle accepts a new result in the same cycle, so each unit sustains 1 result/cycle when uncontended.
- Accept: when req_valid[i]&req_ready[i], set slot_valid[i]=1 and slot_data[i]=req_data[i] at the edge.
- On grant g:
  - slot_valid[g] clears at the edge unless refilled the same cycle.
  - cdb<=slot_data[g], cdb_src<=g, cdb_valid<=1.
  - ptr<=(g+1) mod N_REQ.
- No grant: cdb_valid<=0. cdb and cdb_src hold their last values. ptr holds.
- Latency: result accepted in cycle t becomes valid in its slot in t+1, is granted no earlier than t+1, and appears with cdb_valid=1 in cycle t+2 at the earliest.
- Fairness: a valid slot waits at most N_REQ-1 grants before it is served.
- flush (sampled at the edge):
  - All slot_valid<=0, cdb_valid<=0, no acceptance (req_ready=0 during flush), ptr unchanged.
  - A cdb_valid already high in the flush cycle is still visible in that cycle; consumers squash it themselves.
- Priority at an edge: rst > flush > normal operation.
- Reset mid-operation: buffered results are discarded, and cdb_valid is 0 in the cycle after the reset edge.
- busy drops only when every slot is empty. cdb_valid pulses from the last grant may still follow; callers treat busy|cdb_valid as "results outstanding".

Test Plan:
- Reset, then a single request: unit 2 presents tag=5, data=0xDEAD for 1 cycle at t -> cdb_valid=1, cdb={5,0xDEAD}, cdb_src=2 exactly at t+2; cdb_valid=0 at t+3; ptr=3.
- All 4 units hold req_valid continuously from reset with distinct tags -> cdb_src sequence 0,1,2,3,0,1,... with cdb_valid=1 every cycle from the 3rd cycle on; each req_ready stays high every 4th cycle only (no drops, no duplicates).
- Back-to-back from one unit: unit 1 streams 8 results, others idle -> 8 consecutive cdb_valid pulses, in order, cdb_src=1, req_ready[1] constantly 1.
- Rotation check: slots 0 and 3 valid with ptr=1 -> unit 3 granted first, then unit 0 (ptr wraps to 0 after grant 3).
- Flush with slots 0, 2 and 3 full and cdb_valid=1 in the flush cycle -> cdb_valid=0 next cycle, busy=0, req_ready=0 during flush; previously buffered tags never appear on cdb.
- rst asserted while 3 slots are full and cdb_valid=1 -> the next cycle shows all outputs at reset values, req_ready=all 1, and no stale result is broadcast afterwards.
